// File: rtl/sram_byte_req_ctrl_pkg.sv
// Shared constants, FSM state type and entry-width helper for the byte-wide
// SRAM request controller.
package sram_ctrl_pkg;

   localparam int unsigned DEF_WORD_ADDR_W = 9;
   localparam int unsigned LANES           = 4;
   localparam int unsigned LANE_W          = 8;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_RD_WAIT
   } state_e;

   // Queue entry packs {we, byte address, write byte}.
   function automatic int unsigned entry_width(input int unsigned word_addr_w);
      return 1 + word_addr_w + 2 + LANE_W;
   endfunction

endpackage

// File: rtl/sram_byte_req_ctrl_if.sv
// Byte request/response channel plus the 1rw SRAM macro port.
interface sram_byte_req_ctrl_if
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WORD_ADDR_W = DEF_WORD_ADDR_W
) ();

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [WORD_ADDR_W+1:0]   req_addr;
   logic [LANE_W-1:0]        req_wdata;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [LANE_W-1:0]        rsp_data;

   logic                     ram_clk0;
   logic                     ram_csb0;
   logic                     ram_web0;
   logic [LANES-1:0]         ram_wmask0;
   logic [WORD_ADDR_W-1:0]   ram_addr0;
   logic [LANES*LANE_W-1:0]  ram_din0;
   logic [LANES*LANE_W-1:0]  ram_dout0;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout0,
      output req_ready, rsp_valid, rsp_data,
      output ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0
   );

   modport mem (
      input  ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0,
      output ram_dout0
   );

endinterface

// File: rtl/sram_byte_req_ctrl_fifo.sv
// In-order request queue: pointer-plus-count FIFO, head visible combinationally,
// no pass-through from push to head in the same cycle.
module sram_req_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/sram_byte_req_ctrl.sv
// Byte request front end for a 1rw 32-bit SRAM: queues requests, issues word
// accesses with one-hot lane masks and returns read bytes in order.
module sram_byte_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WORD_ADDR_W = DEF_WORD_ADDR_W,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic               clk,
   input  logic               rst,
   sram_byte_req_ctrl_if.slave bus,
   output logic               busy
);

   localparam int unsigned BYTE_ADDR_W = WORD_ADDR_W + 2;
   localparam int unsigned ENTRY_W     = entry_width(WORD_ADDR_W);

   logic                   push, full, empty, issue;
   logic [ENTRY_W-1:0]     head;
   logic                   head_we;
   logic [BYTE_ADDR_W-1:0] head_addr;
   logic [LANE_W-1:0]      head_wdata;
   logic [1:0]             head_lane;

   state_e                 state_q, state_d;
   logic [1:0]             lane_q, lane_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [LANE_W-1:0]      rsp_data_q, rsp_data_d;

   assign push = bus.req_valid && !full;

   sram_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (issue),
      .wdata ({bus.req_we, bus.req_addr, bus.req_wdata}),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   assign {head_we, head_addr, head_wdata} = head;
   assign head_lane = head_addr[1:0];

   // Writes may slip past a held response; reads wait until it is consumed.
   assign issue = !empty && (state_q == ST_IDLE) && (head_we || !rsp_valid_q);

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (issue && !head_we) begin
               state_d = ST_RD_WAIT;
               lane_d  = head_lane;
            end
         end
         ST_RD_WAIT: begin
            rsp_data_d  = bus.ram_dout0[{lane_q, 3'b000} +: LANE_W];
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lane_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_comb begin
      bus.ram_csb0   = 1'b1;
      bus.ram_web0   = 1'b1;
      bus.ram_wmask0 = '0;
      bus.ram_addr0  = '0;
      bus.ram_din0   = '0;
      if (issue) begin
         bus.ram_csb0  = 1'b0;
         bus.ram_addr0 = head_addr[BYTE_ADDR_W-1:2];
         if (head_we) begin
            bus.ram_web0   = 1'b0;
            bus.ram_wmask0 = LANES'(1) << head_lane;
            bus.ram_din0   = (LANES*LANE_W)'(head_wdata) << {head_lane, 3'b000};
         end
      end
   end

   assign bus.req_ready = !full;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.ram_clk0  = clk;
   assign busy          = !empty || (state_q != ST_IDLE) || rsp_valid_q;

endmodule

// File: doc/sram_byte_req_ctrl.md
Name: sram_byte_req_ctrl

Overview:
- Byte-wide request/response front end that drives the 1rw 32-bit SRAM macro port (clk0/csb0/web0/wmask0/addr0/din0/dout0).
- Upstream logic (pin decoder, UART/SPI bridge) issues single-byte reads/writes over a valid/ready handshake.
- The block queues requests in order, maps each one onto a word access with a one-hot byte mask, and returns read bytes over a valid/ready response channel.

Parameters:
- WORD_ADDR_W, 9, SRAM word address width; byte address width is WORD_ADDR_W+2.
- FIFO_DEPTH, 2, request queue depth; power of two, at least 2.

Ports:
- clk  in  1  single clock; also forwarded as ram_clk0.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept (= !fifo_full).
- req_we  in  1  1=write, 0=read.
- req_addr  in  WORD_ADDR_W+2  byte address; [1:0]=lane, upper bits=word.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  read byte held.
- rsp_ready  in  1  consumer takes byte.
- rsp_data  out  8  read byte.
- busy  out  1  FIFO non-empty, or state != IDLE, or rsp_valid.
- ram_clk0  out  1  = clk.
- ram_csb0  out  1  chip select, active low.
- ram_web0  out  1  write enable, active low.
- ram_wmask0  out  4  byte write mask.
- ram_addr0  out  WORD_ADDR_W  word address.
- ram_din0  out  32  write data.
- ram_dout0  in  32  read data.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, state IDLE, rsp_valid=0, rsp_data=0, lane register=0.
  - Combinationally: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - Reset during RD_WAIT drops the read; no response is produced.
- Accept: push on req_valid&&req_ready. req_ready depends only on full; a pop in the same cycle does not raise it, so there is no pass-through.
  - FIFO entry = {we, addr, wdata}.
- Issue conditions (evaluated combinationally from the FIFO head; the SRAM samples at the same edge that pops the head):
  - Write: FIFO non-empty, state IDLE. rsp_valid does not block writes.
  - Read: FIFO non-empty, state IDLE, rsp_valid=0.
  - A blocked head read stalls all later entries (strict in-order).
- SRAM drive during an issue cycle:
  - csb0=0, addr0=head.addr[top:2].
  - Write: web0=0, wmask0=1<<lane, din0=wdata<<(8*lane), other lanes 0.
  - Read: web0=1, wmask0=0000, din0=0.
- SRAM drive in all other cycles: csb0=1, web0=1, wmask0=0, addr0=0, din0=0. No cycle has both an issue and an outstanding read.
- FSM:
  - IDLE: read issue → RD_WAIT and lane captured; write issue → stay IDLE.
  - RD_WAIT: exactly 1 cycle. At the next edge: rsp_data <= dout0[8*lane +: 8], rsp_valid <= 1, → IDLE. No SRAM access in RD_WAIT.
- Response: rsp_valid clears on rsp_valid&&rsp_ready. A read may issue in the cycle after the handshake, not the same cycle.
- Latency with an idle FIFO:
  - Accept at edge E0, issue at E1.
  - Read: rsp_valid high after E2, so the minimum is 2 cycles from acceptance.
  - Back-to-back writes: one per cycle.
- Ordering: a read after a write to the same byte returns the new data, because the write reaches the SRAM first.
- Address boundaries: top byte address (all ones) → addr0 all ones, lane 3. No wrap logic is needed.

Decomposition:
- Package sram_ctrl_pkg:
  - WORD_ADDR_W default, LANES=4, LANE_W=8.
  - state enum {ST_IDLE, ST_RD_WAIT}.
  - FIFO entry struct/width constant.
- Sub-module sram_req_fifo:
  - Synchronous FIFO: DEPTH and WIDTH parameters, async active-high reset.
  - Ports: push/pop/full/empty/head.
  - Pointer-plus-count design; no pass-through.
- Top level contains issue logic, FSM, lane shift/mux and the response register.

Test Plan:
- Reset: assert rst mid-stream with a read in RD_WAIT → csb0=1, rsp_valid=0, req_ready=1 immediately. No response ever appears for the dropped read.
- Byte write/readback: write 0xA5@0x003, 0x3C@0x000 → wmask0 1000 then 0001, addr0=0 both, din0=0xA5000000 / 0x0000003C. Read 0x003 → rsp_data=0xA5, rsp_valid 2 cycles after accept.
- Lanes/boundary: write 0x11, 0x22, 0x33, 0x44 to 0x7FC..0x7FF → addr0=0x1FF, masks 0001/0010/0100/1000. Read each → bytes return in order.
- Backpressure: two reads queued with rsp_ready=0 → first held stable, second not issued (csb0=1), req_ready=0 once full. Raise rsp_ready → second read issues the next cycle.
- Write past a stalled read: queue read then write while rsp_valid=1 → write waits behind the read (in-order). After drain, csb0 low exactly 2 cycles total and the read returns the pre-write value.
- Streaming: 16 back-to-back writes with req_valid held → one SRAM write per cycle after the first. busy falls 1 cycle after the last issue.
